// File: rtl/mod_pkg.sv
// -----------------------------------------------------------------------------
// mod_pkg
// Shared definitions for the PUSCH modulation mapper sequencer:
//   - modulation code values as carried on cfg_mod
//   - Qm (bits per symbol) lookup
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package mod_pkg;

    localparam logic [1:0] MOD_BPSK  = 2'b00;
    localparam logic [1:0] MOD_QPSK  = 2'b01;
    localparam logic [1:0] MOD_QAM16 = 2'b10;
    localparam logic [1:0] MOD_QAM64 = 2'b11;

    // Widest group (64QAM) sets the width of the LUT address bus.
    localparam int GROUP_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_MAP     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUT     = 3'd4
    } state_t;

    // Bits per constellation symbol for a given modulation code.
    function automatic logic [2:0] qm_of(input logic [1:0] mod);
        logic [2:0] qm;
        qm = 3'd1;
        case (mod)
            MOD_BPSK:  qm = 3'd1;
            MOD_QPSK:  qm = 3'd2;
            MOD_QAM16: qm = 3'd4;
            MOD_QAM64: qm = 3'd6;
            default:   qm = 3'd1;
        endcase
        return qm;
    endfunction

endpackage

// File: rtl/bit_group_shifter.sv
// -----------------------------------------------------------------------------
// bit_group_shifter
// Serial-in shift register that assembles one Qm-bit constellation group.
// The first bit of a group ends up at group_bits[qm-1], the last at bit 0.
// A short final group is left-justified within qm and zero-filled below.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   clr          : clear the group register and bit counter (new group)
//   shift_en     : accept bit_in this cycle
//   bit_in       : serial data bit
//   last_bit     : bit_in is the final bit of the codeword
//   qm           : bits per symbol for the codeword in progress (1,2,4,6)
//   group_bits   : current group, right-aligned, upper bits zero
//   group_done   : combinational; this shift completes the group
//   pad          : combinational; this shift completes a short group
// -----------------------------------------------------------------------------
module bit_group_shifter
    import mod_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic               last_bit,
    input  logic [2:0]         qm,
    output logic [GROUP_W-1:0] group_bits,
    output logic               group_done,
    output logic               pad
);

    logic [GROUP_W-1:0] sr_q, sr_d;
    logic [2:0]         gcnt_q, gcnt_d;
    logic [2:0]         cnt_inc;
    logic [GROUP_W-1:0] shifted;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the branches can leave it unassigned and infer a latch.
        sr_d       = sr_q;
        gcnt_d     = gcnt_q;
        group_done = 1'b0;
        pad        = 1'b0;
        cnt_inc    = gcnt_q + 3'd1;
        shifted    = {sr_q[GROUP_W-2:0], bit_in};

        if (clr) begin
            sr_d   = '0;
            gcnt_d = '0;
        end else if (shift_en) begin
            gcnt_d     = cnt_inc;
            group_done = (cnt_inc == qm) || last_bit;
            pad        = last_bit && (cnt_inc < qm);
            // A short final group is moved up so its first bit still sits at
            // qm-1; the vacated low positions shift in as zeros.
            sr_d       = pad ? (shifted << (qm - cnt_inc)) : shifted;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the pre-edge value of every other flop.
        if (rst) begin
            sr_q   <= '0;
            gcnt_q <= '0;
        end else begin
            sr_q   <= sr_d;
            gcnt_q <= gcnt_d;
        end
    end

    assign group_bits = sr_q;

endmodule

// File: rtl/mod_mapper_ctrl.sv
// -----------------------------------------------------------------------------
// mod_mapper_ctrl
// Sequencer for the PUSCH modulation mapper. Gathers the serial scrambled bit
// stream into Qm-bit groups, fires the matching constellation LUT for one
// cycle, registers the returned I/Q pair and hands it downstream on a
// valid/ready handshake. Modulation order and codeword length are latched
// when a codeword starts.
//
// Ports
//   clk, rst                         : clock, synchronous active-high reset
//   start                            : begin a codeword (honoured in IDLE only)
//   cfg_mod, cfg_num_bits            : modulation code and codeword bit count
//   bit_in, bit_valid, bit_ready     : serial input handshake
//   lut_bits                         : current group to the LUTs, right-aligned
//   en_bpsk/en_qpsk/en_qam16/en_qam64: one-hot, one-cycle LUT enables
//   lut_i, lut_q                     : LUT response (sampled the cycle after
//                                      the enable)
//   sym_i, sym_q, sym_valid,
//   sym_ready, sym_last              : symbol output handshake
//   busy                             : any state other than IDLE
//   err_pad                          : sticky; short last group or zero length
// -----------------------------------------------------------------------------
module mod_mapper_ctrl
    import mod_pkg::*;
#(
    parameter int LUT_WIDTH = 18,
    parameter int LEN_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  cfg_mod,
    input  logic [LEN_WIDTH-1:0]        cfg_num_bits,
    input  logic                        bit_in,
    input  logic                        bit_valid,
    output logic                        bit_ready,
    output logic [5:0]                  lut_bits,
    output logic                        en_bpsk,
    output logic                        en_qpsk,
    output logic                        en_qam16,
    output logic                        en_qam64,
    input  logic signed [LUT_WIDTH-1:0] lut_i,
    input  logic signed [LUT_WIDTH-1:0] lut_q,
    output logic signed [LUT_WIDTH-1:0] sym_i,
    output logic signed [LUT_WIDTH-1:0] sym_q,
    output logic                        sym_valid,
    input  logic                        sym_ready,
    output logic                        sym_last,
    output logic                        busy,
    output logic                        err_pad
);

    state_t                      state_q, state_d;
    logic [1:0]                  mod_q, mod_d;
    logic [LEN_WIDTH-1:0]        rem_q, rem_d;
    logic                        err_pad_q, err_pad_d;
    logic signed [LUT_WIDTH-1:0] sym_i_q, sym_i_d;
    logic signed [LUT_WIDTH-1:0] sym_q_q, sym_q_d;
    logic                        sym_last_q, sym_last_d;
    logic                        sym_valid_q, sym_valid_d;
    logic                        bit_ready_q, bit_ready_d;
    logic                        busy_q, busy_d;
    // Enable vector indexed by modulation code: {qam64, qam16, qpsk, bpsk}.
    logic [3:0]                  en_q, en_d;

    logic                        bit_accept;
    logic                        grp_clr;
    logic                        grp_done;
    logic                        grp_pad;
    logic                        last_bit;
    logic [2:0]                  qm;
    logic [GROUP_W-1:0]          group_bits;

    assign qm         = qm_of(mod_q);
    // bit_ready_q is high exactly while in COLLECT, so this is the transfer.
    assign bit_accept = bit_ready_q && bit_valid;
    assign last_bit   = (rem_q <= LEN_WIDTH'(1));

    bit_group_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .clr        (grp_clr),
        .shift_en   (bit_accept),
        .bit_in     (bit_in),
        .last_bit   (last_bit),
        .qm         (qm),
        .group_bits (group_bits),
        .group_done (grp_done),
        .pad        (grp_pad)
    );

    always_comb begin
        state_d    = state_q;
        mod_d      = mod_q;
        rem_d      = rem_q;
        err_pad_d  = err_pad_q;
        sym_i_d    = sym_i_q;
        sym_q_d    = sym_q_q;
        sym_last_d = sym_last_q;
        grp_clr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_num_bits != '0) begin
                        mod_d     = cfg_mod;
                        rem_d     = cfg_num_bits;
                        err_pad_d = 1'b0;
                        grp_clr   = 1'b1;
                        state_d   = ST_COLLECT;
                    end else begin
                        // Zero-length codeword: flag it and emit nothing.
                        err_pad_d = 1'b1;
                    end
                end
            end

            ST_COLLECT: begin
                if (bit_accept) begin
                    rem_d = (rem_q != '0) ? rem_q - LEN_WIDTH'(1) : '0;
                    if (grp_pad) begin
                        err_pad_d = 1'b1;
                    end
                    if (grp_done) begin
                        state_d = ST_MAP;
                    end
                end
            end

            ST_MAP: begin
                state_d = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                sym_i_d    = lut_i;
                sym_q_d    = lut_q;
                sym_last_d = (rem_q == '0);
                state_d    = ST_OUT;
            end

            ST_OUT: begin
                if (sym_ready) begin
                    grp_clr = 1'b1;
                    state_d = sym_last_q ? ST_IDLE : ST_COLLECT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // exactly with the state they describe, with no decode glitches.
        bit_ready_d = (state_d == ST_COLLECT);
        busy_d      = (state_d != ST_IDLE);
        sym_valid_d = (state_d == ST_OUT);
        en_d        = '0;
        if (state_d == ST_MAP) begin
            en_d[mod_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the symbol datapath registers are reset too, because sym_i and
        // sym_q must read zero after reset, not just be qualified by valid.
        if (rst) begin
            state_q     <= ST_IDLE;
            mod_q       <= '0;
            rem_q       <= '0;
            err_pad_q   <= 1'b0;
            sym_i_q     <= '0;
            sym_q_q     <= '0;
            sym_last_q  <= 1'b0;
            sym_valid_q <= 1'b0;
            bit_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            en_q        <= '0;
        end else begin
            state_q     <= state_d;
            mod_q       <= mod_d;
            rem_q       <= rem_d;
            err_pad_q   <= err_pad_d;
            sym_i_q     <= sym_i_d;
            sym_q_q     <= sym_q_d;
            sym_last_q  <= sym_last_d;
            sym_valid_q <= sym_valid_d;
            bit_ready_q <= bit_ready_d;
            busy_q      <= busy_d;
            en_q        <= en_d;
        end
    end

    assign bit_ready = bit_ready_q;
    assign lut_bits  = group_bits;
    assign en_bpsk   = en_q[MOD_BPSK];
    assign en_qpsk   = en_q[MOD_QPSK];
    assign en_qam16  = en_q[MOD_QAM16];
    assign en_qam64  = en_q[MOD_QAM64];
    assign sym_i     = sym_i_q;
    assign sym_q     = sym_q_q;
    assign sym_valid = sym_valid_q;
    assign sym_last  = sym_last_q;
    assign busy      = busy_q;
    assign err_pad   = err_pad_q;

endmodule

// File: tb/tb_mod_mapper_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mod_mapper_ctrl
// Self-checking bench for mod_mapper_ctrl. A registered stand-in LUT answers
// each enable with a value derived from the group and modulation; a model
// splits each codeword into left-justified Qm-bit groups and predicts the
// groups, symbols, last flags and err_pad.
// -----------------------------------------------------------------------------
module tb_mod_mapper_ctrl;

    localparam int LW = 18;
    localparam int NW = 16;

    localparam logic [1:0] M_BPSK  = 2'd0;
    localparam logic [1:0] M_QPSK  = 2'd1;
    localparam logic [1:0] M_QAM16 = 2'd2;
    localparam logic [1:0] M_QAM64 = 2'd3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [1:0]           cfg_mod = '0;
    logic [NW-1:0]        cfg_num_bits = '0;
    logic                 bit_in = 1'b0;
    logic                 bit_valid = 1'b0;
    logic                 bit_ready;
    logic [5:0]           lut_bits;
    logic                 en_bpsk, en_qpsk, en_qam16, en_qam64;
    logic signed [LW-1:0] lut_i = '0;
    logic signed [LW-1:0] lut_q = '0;
    logic signed [LW-1:0] sym_i, sym_q;
    logic                 sym_valid;
    logic                 sym_ready = 1'b0;
    logic                 sym_last;
    logic                 busy;
    logic                 err_pad;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_pct  = 100;
    int en_bad   = 0;

    logic [5:0]           got_grp[$];
    logic [1:0]           got_en[$];
    logic signed [LW-1:0] got_i[$];
    logic signed [LW-1:0] got_q[$];
    logic                 got_last[$];

    mod_mapper_ctrl #(.LUT_WIDTH(LW), .LEN_WIDTH(NW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_mod      (cfg_mod),
        .cfg_num_bits (cfg_num_bits),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .lut_bits     (lut_bits),
        .en_bpsk      (en_bpsk),
        .en_qpsk      (en_qpsk),
        .en_qam16     (en_qam16),
        .en_qam64     (en_qam64),
        .lut_i        (lut_i),
        .lut_q        (lut_q),
        .sym_i        (sym_i),
        .sym_q        (sym_q),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym_last     (sym_last),
        .busy         (busy),
        .err_pad      (err_pad)
    );

    always #5 clk = ~clk;

    // Stand-in constellation tables: distinct value per (modulation, group).
    function automatic logic signed [LW-1:0] lut_i_f(input logic [1:0] m, input logic [5:0] b);
        int v;
        v = int'(b) * 1000 - 31000 + int'(m) * 7;
        return LW'(v);
    endfunction

    function automatic logic signed [LW-1:0] lut_q_f(input logic [1:0] m, input logic [5:0] b);
        int v;
        v = 100 - int'(b) * 517 + int'(m) * 3;
        return LW'(v);
    endfunction

    function automatic int qm_tb(input logic [1:0] m);
        int r;
        case (m)
            2'd0:    r = 1;
            2'd1:    r = 2;
            2'd2:    r = 4;
            default: r = 6;
        endcase
        return r;
    endfunction

    // Registered LUT: answers in the cycle after its enable.
    always @(posedge clk) begin
        if (en_bpsk)  begin lut_i <= lut_i_f(M_BPSK,  lut_bits); lut_q <= lut_q_f(M_BPSK,  lut_bits); end
        if (en_qpsk)  begin lut_i <= lut_i_f(M_QPSK,  lut_bits); lut_q <= lut_q_f(M_QPSK,  lut_bits); end
        if (en_qam16) begin lut_i <= lut_i_f(M_QAM16, lut_bits); lut_q <= lut_q_f(M_QAM16, lut_bits); end
        if (en_qam64) begin lut_i <= lut_i_f(M_QAM64, lut_bits); lut_q <= lut_q_f(M_QAM64, lut_bits); end
    end

    // Downstream ready, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        sym_ready = ($urandom_range(99) < rdy_pct);
    end

    // Monitor on the falling edge: records LUT requests and accepted symbols.
    always @(negedge clk) begin
        int n_en;
        n_en = int'(en_bpsk) + int'(en_qpsk) + int'(en_qam16) + int'(en_qam64);
        if (!rst) begin
            if (n_en > 1 || (n_en > 0 && (bit_ready || sym_valid))) en_bad++;
            if (n_en > 0) begin
                got_grp.push_back(lut_bits);
                got_en.push_back(en_bpsk ? 2'd0 : en_qpsk ? 2'd1 : en_qam16 ? 2'd2 : 2'd3);
            end
            if (sym_valid && sym_ready) begin
                got_i.push_back(sym_i);
                got_q.push_back(sym_q);
                got_last.push_back(sym_last);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {bit_ready, busy, lut_bits, en_bpsk, en_qpsk, en_qam16, en_qam64,
                     sym_valid, sym_last, err_pad, sym_i, sym_q}, 64'd0);
    endtask

    task automatic clear_monitor();
        got_grp.delete(); got_en.delete();
        got_i.delete(); got_q.delete(); got_last.delete();
        en_bad = 0;
    endtask

    // Runs one codeword end to end and compares everything against the model.
    // bits[k] is the k-th serial bit. glitch pulses start while busy.
    task automatic run_cw(input logic [1:0] mod, input int nbits, input logic [63:0] bits,
                          input int vpct, input bit glitch,
                          output int nsym, output logic [5:0] first_grp);
        int qm, ngrp, i, t, n;
        logic acc;
        logic [5:0] eg;
        clear_monitor();
        @(posedge clk); #1;
        start = 1'b1; cfg_mod = mod; cfg_num_bits = NW'(nbits);
        @(posedge clk); #1;
        start = 1'b0;
        cfg_mod = 2'($urandom); cfg_num_bits = NW'($urandom);
        i = 0; t = 0;
        while (i < nbits && t < 5000) begin
            bit_valid = ($urandom_range(99) < vpct);
            bit_in    = bit_valid ? bits[i] : 1'($urandom);
            start     = glitch && (i == 1);
            if (start) begin cfg_mod = 2'($urandom); cfg_num_bits = NW'($urandom_range(3, 1)); end
            acc = bit_valid && bit_ready;
            @(posedge clk); #1;
            if (acc) i++;
            t++;
        end
        bit_valid = 1'b0; start = 1'b0;
        t = 0;
        while (busy && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("cw_done", {63'd0, busy}, 64'd0);

        qm   = qm_tb(mod);
        ngrp = (nbits + qm - 1) / qm;
        check("n_groups", got_grp.size(), ngrp);
        check("n_symbols", got_i.size(), ngrp);
        check("en_discipline", en_bad, 0);
        n = (got_grp.size() < ngrp) ? got_grp.size() : ngrp;
        for (int g = 0; g < n; g++) begin
            eg = '0;
            for (int j = 0; j < qm; j++) begin
                if (g * qm + j < nbits) eg[qm - 1 - j] = bits[g * qm + j];
            end
            check("group_bits", got_grp[g], eg);
            check("enable_sel", got_en[g], mod);
            if (g < got_i.size()) begin
                check("sym_i", got_i[g], lut_i_f(mod, eg));
                check("sym_q", got_q[g], lut_q_f(mod, eg));
                check("sym_last", got_last[g], (g == ngrp - 1));
            end
        end
        check("err_pad", err_pad, (nbits % qm) != 0);
        nsym      = got_i.size();
        first_grp = (got_grp.size() > 0) ? got_grp[0] : 6'd0;
    endtask

    typedef struct {
        logic [1:0]  mod;
        int          nbits;
        logic [63:0] bits;
        int          exp_nsym;
        logic        exp_err;
        logic [5:0]  exp_first;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int         nsym, t;
        logic [5:0] fg;
        logic [63:0] pat;

        // Bits listed first-to-last map to bits[0], bits[1], ...
        vecs[0] = '{M_QPSK,  8, 64'h39, 4, 1'b0, 6'b000010}; // 1,0,0,1,1,1,0,0
        vecs[1] = '{M_QAM16, 4, 64'hE,  1, 1'b0, 6'b000111}; // 0,1,1,1
        vecs[2] = '{M_QAM64, 8, 64'hED, 2, 1'b1, 6'b101101}; // 1,0,1,1,0,1,1,1
        vecs[3] = '{M_BPSK,  3, 64'h5,  3, 1'b0, 6'b000001}; // 1,0,1
        vecs[4] = '{M_QPSK,  3, 64'h7,  2, 1'b1, 6'b000011}; // 1,1,1

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("idle_after_reset");

        // Table-driven codewords with free-running handshakes.
        rdy_pct = 100;
        for (int v = 0; v < 5; v++) begin
            run_cw(vecs[v].mod, vecs[v].nbits, vecs[v].bits, 100, 1'b0, nsym, fg);
            check("tbl_nsym", nsym, vecs[v].exp_nsym);
            check("tbl_err_pad", err_pad, vecs[v].exp_err);
            check("tbl_first_group", fg, vecs[v].exp_first);
        end

        // Latency: 16QAM, 4th bit accepted in cycle n -> sym_valid in n+3.
        clear_monitor();
        pat = 64'hE;
        @(posedge clk); #1;
        start = 1'b1; cfg_mod = M_QAM16; cfg_num_bits = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("lat_bit_ready", bit_ready, 1'b1);
            bit_valid = 1'b1; bit_in = pat[k];
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        @(negedge clk);
        check("lat_map_en", {en_bpsk, en_qpsk, en_qam16, en_qam64}, 4'b0010);
        check("lat_map_bits", lut_bits, 6'b000111);
        check("lat_n1_valid", sym_valid, 1'b0);
        @(negedge clk);
        check("lat_n2_valid", sym_valid, 1'b0);
        @(negedge clk);
        check("lat_n3_valid", sym_valid, 1'b1);
        check("lat_n3_last", sym_last, 1'b1);
        check("lat_n3_sym_i", sym_i, lut_i_f(M_QAM16, 6'b000111));
        t = 0;
        while (busy && t < 50) begin @(negedge clk); t++; end
        check("lat_done", busy, 1'b0);

        // Backpressure: symbol and flags hold while sym_ready is low.
        rdy_pct = 0;
        clear_monitor();
        @(posedge clk); #1;
        start = 1'b1; cfg_mod = M_QPSK; cfg_num_bits = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        bit_valid = 1'b1; bit_in = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bit_valid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!sym_valid && t < 20) begin @(negedge clk); t++; end
        check("bp_valid", sym_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", {sym_valid, sym_last, bit_ready, sym_ready},
                  {1'b1, 1'b1, 1'b0, 1'b0});
            check("bp_sym_i", sym_i, lut_i_f(M_QPSK, 6'b000011));
            check("bp_sym_q", sym_q, lut_q_f(M_QPSK, 6'b000011));
            @(negedge clk);
        end
        rdy_pct = 100;
        @(negedge clk);
        check("bp_release", {sym_valid, sym_ready}, 2'b11);
        @(negedge clk);
        check("bp_after", {sym_valid, busy}, 2'b00);

        // Zero-length codeword: flag only, nothing emitted.
        clear_monitor();
        @(posedge clk); #1;
        start = 1'b1; cfg_mod = M_QAM64; cfg_num_bits = '0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("zero_len_state", {busy, err_pad}, 2'b01);
        end
        check("zero_len_enables", got_grp.size(), 0);

        // start while busy is ignored; err_pad clears on the honoured start.
        run_cw(M_QPSK, 4, 64'h9, 100, 1'b1, nsym, fg);
        check("glitch_nsym", nsym, 2);
        check("glitch_first", fg, 6'b000010);

        // Reset after 3 of 4 16QAM bits.
        @(posedge clk); #1;
        start = 1'b1; cfg_mod = M_QAM16; cfg_num_bits = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        bit_valid = 1'b1; bit_in = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bit_valid = 1'b0;
        @(negedge clk);
        check_outputs_zero("rst_mid_collect");
        @(negedge clk);
        check_outputs_zero("rst_stays_idle");
        run_cw(M_QAM16, 4, 64'h9, 100, 1'b0, nsym, fg);
        check("post_rst_first", fg, 6'b001001);

        // Randomised codewords against the model.
        for (int r = 0; r < 40; r++) begin
            logic [1:0] m;
            int         nb;
            bit         gl;
            m       = 2'($urandom_range(3));
            nb      = $urandom_range(40, 1);
            pat     = {$urandom, $urandom};
            rdy_pct = $urandom_range(100, 30);
            gl      = (nb > 1) && ($urandom_range(1) == 1);
            run_cw(m, nb, pat, $urandom_range(100, 40), gl, nsym, fg);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mod_mapper_ctrl.md
Name: mod_mapper_ctrl

Overview:
- Sequencer for the PUSCH modulation mapper.
- Collects the serial scrambled bit stream into Qm-bit groups and drives the group into the selected constellation LUT (BPSK/QPSK/16QAM/64QAM) with a one-cycle enable.
- Registers the returned I/Q pair and presents it downstream on a valid/ready handshake.
- Frame length and modulation order are latched per codeword at start.

Parameters:
- LUT_WIDTH, 18, width of the signed I/Q values returned by the LUTs and sent downstream.
- LEN_WIDTH, 16, width of the codeword bit-count field.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins a codeword; ignored unless IDLE.
- cfg_mod  in  2  00 BPSK (Qm=1), 01 QPSK (Qm=2), 10 16QAM (Qm=4), 11 64QAM (Qm=6).
- cfg_num_bits  in  LEN_WIDTH  codeword length in bits.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in valid.
- bit_ready  out  1  controller accepts a bit; transfer when bit_valid & bit_ready.
- lut_bits  out  6  current group, right-aligned; upper bits zero.
- en_bpsk, en_qpsk, en_qam16, en_qam64  out  1 each  one-hot one-cycle LUT enable.
- lut_i, lut_q  in  LUT_WIDTH signed  LUT outputs.
- sym_i, sym_q  out  LUT_WIDTH signed  registered symbol.
- sym_valid  out  1  symbol valid.
- sym_ready  in  1  downstream accepts.
- sym_last  out  1  qualifies the final symbol of the codeword.
- busy  out  1  high in every state except IDLE.
- err_pad  out  1  sticky; the last group was zero-padded, or cfg_num_bits was 0. Cleared on start or rst.

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything, including mid-codeword.
  - State goes to IDLE.
  - All outputs are 0, including sym_i/sym_q, lut_bits and err_pad.
  - Counters are cleared. No partial symbol is emitted after reset.
- IDLE:
  - On start with cfg_num_bits != 0: latch mod/Qm and num_bits, clear err_pad, go to COLLECT.
  - On start with cfg_num_bits == 0: set err_pad and stay in IDLE; no symbols are emitted.
- COLLECT:
  - bit_ready=1.
  - Each accepted bit shifts in so that the first bit of a group lands at lut_bits[Qm-1] and the last at lut_bits[0].
  - Group counter gcnt increments; remaining-bits counter rem decrements.
  - Go to MAP when gcnt reaches Qm or rem reaches 0.
  - If rem hits 0 with gcnt < Qm: left-justify the partial group within Qm, zero-fill the low bits, and set err_pad.
- MAP (1 cycle):
  - bit_ready=0.
  - Exactly the enable matching the latched mod is 1; lut_bits is stable.
  - Next state is CAPTURE.
- CAPTURE (1 cycle):
  - Register lut_i/lut_q into sym_i/sym_q.
  - Register sym_last = (rem==0).
  - Next state is OUT, with sym_valid=1 from the first OUT cycle.
- OUT:
  - sym_valid, sym_i, sym_q and sym_last hold stable until sym_ready.
  - On sym_valid & sym_ready: go to IDLE if last, else to COLLECT with gcnt=0 and lut_bits cleared.
- Latency: the Qm-th bit is accepted in cycle n; sym_valid rises in cycle n+3.
- Throughput: at most one symbol per Qm+3 cycles.
- Enable discipline: the enables are never high outside MAP and are never simultaneously high.
- Input handling:
  - bit_valid outside COLLECT is ignored and bits are not consumed.
  - start outside IDLE is ignored.
  - cfg_* changes after start have no effect on the codeword in progress.
- Counters: rem and gcnt are unsigned and never wrap. rem saturates at 0.

Decomposition:
- Shared package (mod_pkg) holds:
  - the mod code localparams (MOD_BPSK, MOD_QPSK, MOD_QAM16, MOD_QAM64);
  - the Qm lookup function;
  - the FSM state encoding.
- One sub-module, bit_group_shifter: serial-in shift register with Qm-aware alignment and pad, plus gcnt. The FSM stays in mod_mapper_ctrl.

Test Plan:
1. QPSK, num_bits=8, bits 1,0,0,1,1,1,0,0, sym_ready=1 → lut_bits sequence 10,01,11,00; four en_qpsk pulses; four symbols; sym_last only on the 4th; err_pad=0.
2. 16QAM, num_bits=4, bits 0,1,1,1 → lut_bits=0111; one en_qam16 pulse; sym_valid exactly 3 cycles after the 4th bit accepted; sym_last=1.
3. 64QAM, num_bits=8 → first group of 6 bits, then a 2-bit group padded to xx0000; err_pad=1 after the second symbol; 2 symbols total.
4. Backpressure: hold sym_ready=0 for 5 cycles in OUT → sym_i/sym_q/sym_last stable and bit_ready=0 throughout; release → transfer in one cycle.
5. num_bits=0 start → err_pad=1, busy stays 0, no enables; also start asserted while busy → ignored and the codeword completes unchanged.
6. rst asserted mid-COLLECT after 3 of 4 16QAM bits → next cycle IDLE, all outputs 0; a new start produces correct symbols with no stale bits.
